// File: rtl/const_tune_pkg.sv
// Shared constants, selection encodings and repeat-FSM state type for the
// PID constant front-panel controller.
package const_tune_pkg;

    localparam int NUM_CHAN  = 5;
    localparam int NUM_FIELD = 3;

    localparam logic [3:0] CH_5V = 4'd0;
    localparam logic [3:0] CH_33 = 4'd1;
    localparam logic [3:0] CH_15 = 4'd2;
    localparam logic [3:0] CH_12 = 4'd3;
    localparam logic [3:0] CH_FB = 4'd4;

    localparam logic [3:0] FLD_KI  = 4'd0;
    localparam logic [3:0] FLD_KP  = 4'd1;
    localparam logic [3:0] FLD_TGT = 4'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } rpt_state_t;

    // Wrapping increment; anything at or past the last legal code returns to 0.
    function automatic logic [3:0] wrapInc(input logic [3:0] v, input logic [3:0] last);
        return (v >= last) ? 4'd0 : v + 4'd1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button front end: 2-FF synchronizer, debounce counter, accepted
// level and a one-cycle press pulse on each accepted 0->1 change.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic n_rst,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_press;

    // The counter only runs while the synchronized sample disagrees with the
    // accepted level, so a single agreeing sample restarts the qualification.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_sync  <= 2'b00;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], btn};
            r_press <= 1'b0;
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                r_cnt   <= '0;
                r_level <= r_sync[1];
                r_press <= r_sync[1];
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign level = r_level;
    assign press = r_press;

endmodule

// File: rtl/const_tune_ctrl.sv
// Front-panel initiator: debounced buttons drive channel/field selection and
// inc/dec pulses. Hold-to-repeat is built only when TUNE_AUTOREPEAT_EN is defined.
module const_tune_ctrl
    import const_tune_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_field,
    input  logic       btn_chan,
    output logic       inc_const,
    output logic       dec_const,
    output logic [3:0] choose_c,
    output logic [3:0] choose
);

    logic w_levelUp, w_levelDown, w_levelField, w_levelChan;
    logic w_pressUp, w_pressDown, w_pressField, w_pressChan;
    logic w_selChange, w_upEv, w_dnEv, w_anyEv;
    logic w_incReq, w_decReq;
    logic w_unusedLvl;

    logic       r_inc;
    logic       r_dec;
    logic [3:0] r_chooseC;
    logic [3:0] r_choose;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbUp (
        .clk(clk), .n_rst(n_rst), .btn(btn_up), .level(w_levelUp), .press(w_pressUp)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbDown (
        .clk(clk), .n_rst(n_rst), .btn(btn_down), .level(w_levelDown), .press(w_pressDown)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbField (
        .clk(clk), .n_rst(n_rst), .btn(btn_field), .level(w_levelField), .press(w_pressField)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbChan (
        .clk(clk), .n_rst(n_rst), .btn(btn_chan), .level(w_levelChan), .press(w_pressChan)
    );

    assign w_unusedLvl = w_levelField ^ w_levelChan;

    // Adjust requests are suppressed while the selection is moving so the
    // store never edits a field that is being deselected.
    assign w_selChange = w_pressChan | w_pressField;
    assign w_upEv      = w_pressUp & ~w_pressDown & ~w_selChange;
    assign w_dnEv      = w_pressDown & ~w_pressUp & ~w_selChange;
    assign w_anyEv     = w_upEv | w_dnEv;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_chooseC <= CH_5V;
            r_choose  <= FLD_KI;
        end else if (w_pressChan) begin
            r_chooseC <= wrapInc(r_chooseC, 4'(NUM_CHAN - 1));
            r_choose  <= FLD_KI;
        end else if (w_pressField) begin
            r_choose <= wrapInc(r_choose, 4'(NUM_FIELD - 1));
        end
    end

`ifdef TUNE_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RCW     = (RPT_MAX > 2) ? $clog2(RPT_MAX) : 1;

    rpt_state_t     r_state;
    logic           r_dirUp;
    logic [RCW-1:0] r_rptCnt;
    logic           w_latchedLvl, w_oppLvl, w_exit, w_rptFire;

    assign w_latchedLvl = r_dirUp ? w_levelUp : w_levelDown;
    assign w_oppLvl     = r_dirUp ? w_levelDown : w_levelUp;
    assign w_exit       = (r_state != ST_IDLE) && (!w_latchedLvl || w_oppLvl);
    assign w_rptFire    = !w_exit && !w_anyEv &&
                          (((r_state == ST_DELAY)  && (r_rptCnt == RCW'(REPEAT_DELAY - 1))) ||
                           ((r_state == ST_REPEAT) && (r_rptCnt == RCW'(REPEAT_PERIOD - 1))));

    // A fresh single-direction press always (re)starts the delay phase; release
    // or the opposite button aborts silently.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state  <= ST_IDLE;
            r_dirUp  <= 1'b0;
            r_rptCnt <= '0;
        end else if (w_anyEv) begin
            r_state  <= ST_DELAY;
            r_dirUp  <= w_upEv;
            r_rptCnt <= '0;
        end else if (w_exit) begin
            r_state  <= ST_IDLE;
            r_rptCnt <= '0;
        end else if (w_rptFire) begin
            r_state  <= ST_REPEAT;
            r_rptCnt <= '0;
        end else if (r_state != ST_IDLE) begin
            r_rptCnt <= r_rptCnt + 1'b1;
        end
    end

    assign w_incReq = ~w_selChange & (w_upEv | (w_rptFire &  r_dirUp));
    assign w_decReq = ~w_selChange & (w_dnEv | (w_rptFire & ~r_dirUp));
`else
    logic w_unusedRpt;

    assign w_unusedRpt = w_levelUp ^ w_levelDown ^ (REPEAT_DELAY != 0) ^ (REPEAT_PERIOD != 0);
    assign w_incReq    = w_upEv;
    assign w_decReq    = w_dnEv;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_inc <= 1'b0;
            r_dec <= 1'b0;
        end else begin
            r_inc <= w_incReq;
            r_dec <= w_decReq;
        end
    end

    assign inc_const = r_inc;
    assign dec_const = r_dec;
    assign choose_c  = r_chooseC;
    assign choose    = r_choose;

endmodule
